// File: rtl/morse_pkg.sv
// ============================================================================
// Module  : morse_pkg
// Purpose : Shared definitions for the Morse transmit sequencer: letter
//           pattern table, sequencer state encoding and a constant clog2.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package morse_pkg;

    localparam int LETTER_W = 3;
    localparam int PAT_BITS = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Symbol patterns, MSB shifted out first.
    localparam logic [PAT_BITS-1:0] LETTER_PAT [0:7] = '{
        12'b010111000000,
        12'b011101010100,
        12'b011101011101,
        12'b011101010000,
        12'b010000000000,
        12'b010101110100,
        12'b011101110100,
        12'b010101010000
    };

    // Bits needed to hold values 0..value-1 (constant elaboration only).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/morse_letter_fifo.sv
// ============================================================================
// Module  : morse_letter_fifo
// Purpose : Small synchronous letter queue with synchronous clear.
// Ports   : clk_i, rst_ni (async active-low), clear_i (drops all entries and
//           any push/pop in the same cycle), push_i/data_i, pop_i/data_o
//           (head, valid while !empty_o), empty_o, full_o.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module morse_letter_fifo
    import morse_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/morse_tx_ctrl.sv
// ============================================================================
// Module  : morse_tx_ctrl
// Purpose : Morse transmit sequencer. Queues letter codes, parallel-loads the
//           looked-up pattern into the external shift register, then issues
//           one shift strobe per symbol tick until PAT_W bits have gone out.
//           Owns the symbol-rate timer.
// Ports   : ClockIn, Resetn (async active-low)
//           LetterValid/Letter/LetterReady : letter push handshake
//           Abort      : flush queue, blank the line, return to idle
//           ShiftLoadn : active-low load strobe, PatternOut valid with it
//           ShiftEn    : one-cycle shift strobe per symbol tick
//           Busy       : sequencer active or letters queued
//           LetterDone : pulse when a letter (and its gap) has finished
// Config  : MORSE_GAP_EN - when defined, GAP_UNITS blank symbol units are
//           inserted after each letter before LetterDone.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module morse_tx_ctrl
    import morse_pkg::*;
#(
    parameter int TICK_DIV  = 250,
    parameter int PAT_W     = 12,
    parameter int DEPTH     = 4,
    parameter int GAP_UNITS = 3
) (
    input  logic             ClockIn,
    input  logic             Resetn,
    input  logic             LetterValid,
    input  logic [2:0]       Letter,
    output logic             LetterReady,
    input  logic             Abort,
    output logic             ShiftLoadn,
    output logic             ShiftEn,
    output logic [PAT_W-1:0] PatternOut,
    output logic             Busy,
    output logic             LetterDone
);

    localparam int TICK_W = clog2(TICK_DIV);
    // One counter serves both the bit count and the gap unit count.
    localparam int CNT_W  = clog2(((PAT_W > GAP_UNITS) ? PAT_W : GAP_UNITS) + 1);

    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(PAT_W - 1);
`ifdef MORSE_GAP_EN
    localparam logic [CNT_W-1:0]  LAST_GAP    = CNT_W'(GAP_UNITS - 1);
`endif

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q,  tick_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [2:0]        fifo_head;

    assign LetterReady = !fifo_full;
    assign Busy        = (state_q != ST_IDLE) || !fifo_empty;

    morse_letter_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (LETTER_W)
    ) u_fifo (
        .clk_i   (ClockIn),
        .rst_ni  (Resetn),
        .clear_i (Abort),
        .push_i  (LetterValid && LetterReady),
        .data_i  (Letter),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        cnt_d      = cnt_q;
        fifo_pop   = 1'b0;
        ShiftLoadn = 1'b1;
        ShiftEn    = 1'b0;
        PatternOut = '0;
        LetterDone = 1'b0;

        if (Abort) begin
            // Loading zeros blanks the line; strobes and done are suppressed.
            state_d    = ST_IDLE;
            tick_d     = '0;
            cnt_d      = '0;
            ShiftLoadn = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_d = ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    fifo_pop   = 1'b1;
                    ShiftLoadn = 1'b0;
                    PatternOut = PAT_W'(LETTER_PAT[fifo_head]);
                    tick_d     = TICK_RELOAD;
                    cnt_d      = '0;
                    state_d    = ST_SEND;
                end

                ST_SEND: begin
                    if (tick_q == '0) begin
                        ShiftEn = 1'b1;
                        tick_d  = TICK_RELOAD;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
`ifdef MORSE_GAP_EN
                            cnt_d   = '0;
                            state_d = ST_GAP;
`else
                            LetterDone = 1'b1;
                            state_d    = fifo_empty ? ST_IDLE : ST_LOAD;
`endif
                        end
                    end else begin
                        tick_d = tick_q - TICK_W'(1);
                    end
                end

`ifdef MORSE_GAP_EN
                ST_GAP: begin
                    if (tick_q == '0) begin
                        tick_d = TICK_RELOAD;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_GAP) begin
                            LetterDone = 1'b1;
                            state_d    = fifo_empty ? ST_IDLE : ST_LOAD;
                        end
                    end else begin
                        tick_d = tick_q - TICK_W'(1);
                    end
                end
`endif

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire
